// File: rtl/bp_core_prof_pkg.sv
// Shared definitions for the BlackParrot core stall profiler.
//
// Contents:
//   bp_num_stall_reasons_gp  number of stall reasons (index 0 = unknown,
//                            higher index = higher attribution priority)
//   bp_num_stall_stages_gp   depth of the stall-attribution pipe (IF1..commit)
//   bp_stall_reason_e        symbolic names for the reason indices
//   bp_stall_reason_s        decoded reason plus a valid flag
//   bp_stall_stage_mask_gp   default injection table, one num_reasons-wide
//                            slice per stage, IF1 in the least significant slice
package bp_core_prof_pkg;

  localparam int bp_num_stall_reasons_gp = 33;
  localparam int bp_num_stall_stages_gp  = 7;

  typedef enum logic [5:0] {
    e_unknown         = 6'd0,
    e_icache_miss     = 6'd1,
    e_icache_fence    = 6'd2,
    e_branch_override = 6'd3,
    e_ret_override    = 6'd4,
    e_fe_cmd          = 6'd5,
    e_fe_cmd_fence    = 6'd6,
    e_mispredict      = 6'd7,
    e_replay          = 6'd8,
    e_control_haz     = 6'd9,
    e_long_haz        = 6'd10,
    e_data_haz        = 6'd11,
    e_aux_dep         = 6'd12,
    e_load_dep        = 6'd13,
    e_mul_dep         = 6'd14,
    e_fma_dep         = 6'd15,
    e_sb_iraw_dep     = 6'd16,
    e_sb_fraw_dep     = 6'd17,
    e_sb_iwaw_dep     = 6'd18,
    e_sb_fwaw_dep     = 6'd19,
    e_struct_haz      = 6'd20,
    e_idiv_haz        = 6'd21,
    e_fdiv_haz        = 6'd22,
    e_ptw_busy        = 6'd23,
    e_special         = 6'd24,
    e_exception       = 6'd25,
    e_interrupt       = 6'd26,
    e_itlb_miss       = 6'd27,
    e_dtlb_miss       = 6'd28,
    e_dcache_miss     = 6'd29,
    e_dcache_fail     = 6'd30,
    e_mem_fence       = 6'd31,
    e_csr_fence       = 6'd32
  } bp_stall_reason_e;

  typedef struct packed {
    logic             v;
    bp_stall_reason_e reason;
  } bp_stall_reason_s;

  // Probe points in every stage (IF1, IF2, ISD, EX1, EX2, EX3, commit) may
  // raise any reason, so every slice of the injection table is fully enabled.
  localparam logic [bp_num_stall_stages_gp*bp_num_stall_reasons_gp-1:0]
    bp_stall_stage_mask_gp = '1;

endpackage

// File: rtl/bp_core_stall_attrib.sv
// Stall-attribution pipe plus priority encoder.
//
// Stall events are ORed into the pipe at the stage where they are allowed to
// be injected (stage_mask_p) and ride down to the commit stage, so a reason is
// charged exactly num_stages_p cycles after it entered at stage 0.
//
// Ports:
//   clk_i, reset_li  clock, asynchronous active-low reset
//   freeze_i         hold every pipe stage
//   clear_i          synchronous clear of the pipe (wins over freeze)
//   event_i          raw stall events this cycle
//   reason_o         highest set index of the commit-stage vector, 0 if empty
//   v_o              commit-stage vector is non-empty
module bp_core_stall_attrib
  import bp_core_prof_pkg::*;
#(
  parameter int num_reasons_p = bp_num_stall_reasons_gp,
  parameter int num_stages_p  = bp_num_stall_stages_gp,
  parameter logic [num_stages_p*num_reasons_p-1:0] stage_mask_p = '1,
  localparam int reason_w_lp = $clog2(num_reasons_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_li,
  input  logic                     freeze_i,
  input  logic                     clear_i,
  input  logic [num_reasons_p-1:0] event_i,
  output logic [reason_w_lp-1:0]   reason_o,
  output logic                     v_o
);

  logic [num_reasons_p-1:0] stage_r [num_stages_p];
  logic [num_reasons_p-1:0] stage_n [num_stages_p];
  logic [num_reasons_p-1:0] decoded;

  always_comb begin
    stage_n[0] = event_i & stage_mask_p[0 +: num_reasons_p];
    for (int s = 1; s < num_stages_p; s++) begin
      stage_n[s] = stage_r[s-1] | (event_i & stage_mask_p[s*num_reasons_p +: num_reasons_p]);
    end
  end

  always_ff @(posedge clk_i or negedge reset_li) begin
    if (!reset_li) begin
      for (int s = 0; s < num_stages_p; s++) stage_r[s] <= '0;
    end else if (clear_i) begin
      for (int s = 0; s < num_stages_p; s++) stage_r[s] <= '0;
    end else if (!freeze_i) begin
      for (int s = 0; s < num_stages_p; s++) stage_r[s] <= stage_n[s];
    end
  end

  assign decoded = stage_r[num_stages_p-1];

  // Ascending scan: the last hit is the highest index, i.e. highest priority.
  always_comb begin
    reason_o = '0;
    for (int i = 0; i < num_reasons_p; i++) begin
      if (decoded[i]) reason_o = reason_w_lp'(i);
    end
  end

  assign v_o = |decoded;

endmodule

// File: rtl/bp_core_stall_histogram.sv
// Synthesizable stall-attribution histogram for the BlackParrot core.
//
// Every unfrozen cycle charges exactly one saturating counter: the instret
// counter (index num_reasons_p) when an instruction retires, otherwise the
// counter of the reason decoded at the commit end of the attribution pipe.
//
// Ports:
//   clk_i, reset_li  clock, asynchronous active-low reset
//   freeze_i         core frozen: no counting, pipe holds
//   event_i          raw stall events this cycle
//   instret_i        commit retired an instruction this cycle
//   clear_i          synchronous clear of counters, pipe and sat_o
//   snapshot_i       (BP_CORE_STALL_HIST_SNAPSHOT_EN only) copy live bank to shadow
//   rd_v_i, rd_addr_i  read request and counter index
//   rd_data_o, rd_v_o  registered read response
//   sat_o            sticky: some counter reached all-ones
//
// Read port: valid-only, no backpressure. A request sampled with rd_v_i=1 at
// an edge is answered by rd_v_o=1 for exactly the following cycle; rd_data_o
// carries the counter value as it was before that edge and otherwise holds.
//
// Build option BP_CORE_STALL_HIST_SNAPSHOT_EN adds a shadow bank; reads then
// return the shadow, which clear_i leaves untouched.
module bp_core_stall_histogram
  import bp_core_prof_pkg::*;
#(
  parameter int num_reasons_p = bp_num_stall_reasons_gp,
  parameter int num_stages_p  = bp_num_stall_stages_gp,
  parameter int cnt_width_p   = 32,
  parameter logic [num_stages_p*num_reasons_p-1:0] stage_mask_p = '1,
  localparam int addr_w_lp   = $clog2(num_reasons_p+1),
  localparam int reason_w_lp = $clog2(num_reasons_p),
  localparam int num_cnt_lp  = num_reasons_p + 1
) (
  input  logic                     clk_i,
  input  logic                     reset_li,
  input  logic                     freeze_i,
  input  logic [num_reasons_p-1:0] event_i,
  input  logic                     instret_i,
  input  logic                     clear_i,
`ifdef BP_CORE_STALL_HIST_SNAPSHOT_EN
  input  logic                     snapshot_i,
`endif
  input  logic                     rd_v_i,
  input  logic [addr_w_lp-1:0]     rd_addr_i,
  output logic [cnt_width_p-1:0]   rd_data_o,
  output logic                     rd_v_o,
  output logic                     sat_o
);

  logic [reason_w_lp-1:0] attr_reason;
  logic                   attr_v;

  bp_core_stall_attrib #(
    .num_reasons_p (num_reasons_p),
    .num_stages_p  (num_stages_p),
    .stage_mask_p  (stage_mask_p)
  ) attrib (
    .clk_i    (clk_i),
    .reset_li (reset_li),
    .freeze_i (freeze_i),
    .clear_i  (clear_i),
    .event_i  (event_i),
    .reason_o (attr_reason),
    .v_o      (attr_v)
  );

  logic [cnt_width_p-1:0] cnt_r   [num_cnt_lp];
  logic [cnt_width_p-1:0] cnt_n   [num_cnt_lp];
  logic [cnt_width_p-1:0] rd_bank [num_cnt_lp];
  logic [cnt_width_p-1:0] rd_val;
  logic [addr_w_lp-1:0]   inc_idx;
  logic                   inc_en;
  logic                   sat_hit;
  logic                   sat_r;

  // A clear cycle never counts; its increment would be wiped anyway.
  assign inc_en = !freeze_i && !clear_i;

  always_comb begin
    inc_idx = instret_i ? addr_w_lp'(num_reasons_p)
                        : (attr_v ? addr_w_lp'(attr_reason) : '0);
    sat_hit = 1'b0;
    for (int i = 0; i < num_cnt_lp; i++) begin
      cnt_n[i] = cnt_r[i];
      if (inc_en && (inc_idx == addr_w_lp'(i))) begin
        if (!(&cnt_r[i])) cnt_n[i] = cnt_r[i] + cnt_width_p'(1);
        sat_hit = &cnt_n[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_li) begin
    if (!reset_li) begin
      for (int i = 0; i < num_cnt_lp; i++) cnt_r[i] <= '0;
      sat_r <= 1'b0;
    end else if (clear_i) begin
      for (int i = 0; i < num_cnt_lp; i++) cnt_r[i] <= '0;
      sat_r <= 1'b0;
    end else begin
      for (int i = 0; i < num_cnt_lp; i++) cnt_r[i] <= cnt_n[i];
      sat_r <= sat_r | sat_hit;
    end
  end

  assign sat_o = sat_r;

`ifdef BP_CORE_STALL_HIST_SNAPSHOT_EN
  logic [cnt_width_p-1:0] shadow_r [num_cnt_lp];

  // cnt_n already includes this cycle's increment, so the shadow captures it.
  always_ff @(posedge clk_i or negedge reset_li) begin
    if (!reset_li) begin
      for (int i = 0; i < num_cnt_lp; i++) shadow_r[i] <= '0;
    end else if (snapshot_i) begin
      for (int i = 0; i < num_cnt_lp; i++) shadow_r[i] <= cnt_n[i];
    end
  end

  always_comb begin
    for (int i = 0; i < num_cnt_lp; i++) rd_bank[i] = shadow_r[i];
  end
`else
  always_comb begin
    for (int i = 0; i < num_cnt_lp; i++) rd_bank[i] = cnt_r[i];
  end
`endif

  // Compare-based mux so out-of-range addresses fall through to zero.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < num_cnt_lp; i++) begin
      if (rd_addr_i == addr_w_lp'(i)) rd_val = rd_bank[i];
    end
  end

  always_ff @(posedge clk_i or negedge reset_li) begin
    if (!reset_li) begin
      rd_v_o    <= 1'b0;
      rd_data_o <= '0;
    end else begin
      rd_v_o <= rd_v_i;
      if (rd_v_i) rd_data_o <= rd_val;
    end
  end

endmodule

// File: tb/tb_bp_core_stall_histogram.sv
// Directed bench for bp_core_stall_histogram.
// u_dut: 33 reasons, 7 stages, 32-bit counters, events injectable at stage 0 only.
// u_sat: 4-bit counters with the default all-stage injection mask.
// With BP_CORE_STALL_HIST_SNAPSHOT_EN defined, every read is preceded by a
// frozen snapshot cycle so the shadow mirrors the live bank.
module tb_bp_core_stall_histogram;

  localparam int nr = 33;
  localparam int ns = 7;
  localparam logic [ns*nr-1:0] stage0_mask = {{((ns-1)*nr){1'b0}}, {nr{1'b1}}};

  logic clk;
  logic rst_l;

  // u_dut stimulus / observation
  logic          frz, inst, clr, rdv, snap;
  logic [nr-1:0] ev;
  logic [5:0]    rda;
  logic [31:0]   rdd;
  logic          rvo, sat;

  // u_sat stimulus / observation
  logic          frz_s, inst_s, clr_s, rdv_s, snap_s;
  logic [nr-1:0] ev_s;
  logic [5:0]    rda_s;
  logic [3:0]    rdd_s;
  logic          rvo_s, sat_s;

  int checks;
  int errors;

  bp_core_stall_histogram #(
    .num_reasons_p (nr),
    .num_stages_p  (ns),
    .cnt_width_p   (32),
    .stage_mask_p  (stage0_mask)
  ) u_dut (
    .clk_i      (clk),
    .reset_li   (rst_l),
    .freeze_i   (frz),
    .event_i    (ev),
    .instret_i  (inst),
    .clear_i    (clr),
`ifdef BP_CORE_STALL_HIST_SNAPSHOT_EN
    .snapshot_i (snap),
`endif
    .rd_v_i     (rdv),
    .rd_addr_i  (rda),
    .rd_data_o  (rdd),
    .rd_v_o     (rvo),
    .sat_o      (sat)
  );

  bp_core_stall_histogram #(
    .num_reasons_p (nr),
    .num_stages_p  (ns),
    .cnt_width_p   (4)
  ) u_sat (
    .clk_i      (clk),
    .reset_li   (rst_l),
    .freeze_i   (frz_s),
    .event_i    (ev_s),
    .instret_i  (inst_s),
    .clear_i    (clr_s),
`ifdef BP_CORE_STALL_HIST_SNAPSHOT_EN
    .snapshot_i (snap_s),
`endif
    .rd_v_i     (rdv_s),
    .rd_addr_i  (rda_s),
    .rd_data_o  (rdd_s),
    .rd_v_o     (rvo_s),
    .sat_o      (sat_s)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic rd_raw(input int addr, input logic [31:0] exp, input string tag);
    rdv = 1'b1;
    rda = addr[5:0];
    tick(1);
    rdv = 1'b0;
    chk({tag, "_v"}, 32'(rvo), 32'd1);
    chk(tag, rdd, exp);
  endtask

  // Caller holds frz=1 so the optional snapshot cycle changes nothing.
  task automatic rd_dut(input int addr, input logic [31:0] exp, input string tag);
`ifdef BP_CORE_STALL_HIST_SNAPSHOT_EN
    snap = 1'b1;
    tick(1);
    snap = 1'b0;
`endif
    rd_raw(addr, exp, tag);
  endtask

  task automatic rd_sat(input int addr, input logic [31:0] exp, input string tag);
`ifdef BP_CORE_STALL_HIST_SNAPSHOT_EN
    snap_s = 1'b1;
    tick(1);
    snap_s = 1'b0;
`endif
    rdv_s = 1'b1;
    rda_s = addr[5:0];
    tick(1);
    rdv_s = 1'b0;
    chk({tag, "_v"}, 32'(rvo_s), 32'd1);
    chk(tag, {28'd0, rdd_s}, exp);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_l  = 1'b0;
    frz = 1'b0; inst = 1'b0; clr = 1'b0; rdv = 1'b0; snap = 1'b0; ev = '0; rda = '0;
    frz_s = 1'b0; inst_s = 1'b0; clr_s = 1'b0; rdv_s = 1'b0; snap_s = 1'b0; ev_s = '0; rda_s = '0;

    // reset state
    tick(3);
    chk("rst_rd_v", 32'(rvo), 32'd0);
    chk("rst_rd_data", rdd, 32'd0);
    chk("rst_sat", 32'(sat), 32'd0);
    chk("rst_sat_s", 32'(sat_s), 32'd0);

    // ten idle cycles charge reason 0
    rst_l = 1'b1;
    tick(10);
    frz = 1'b1;
    rd_dut(0, 10, "idle_r0");
    tick(1);
    chk("rd_v_drop", 32'(rvo), 32'd0);
    chk("rd_hold", rdd, 32'd10);
    rd_dut(40, 0, "oor_addr");
    rd_dut(5, 0, "idle_r5");
    rd_dut(32, 0, "idle_r32");
    rd_dut(33, 0, "idle_instret");

    // single event at stage 0 is charged exactly 7 cycles later
    clr = 1'b1; tick(1); clr = 1'b0;
    frz = 1'b0;
    ev = 33'd1 << 5;
    tick(1);
    ev = '0;
    tick(6);
    frz = 1'b1;
    rd_dut(5, 0, "lat_r5_early");
    rd_dut(0, 7, "lat_r0_early");
    frz = 1'b0; tick(1); frz = 1'b1;
    rd_dut(5, 1, "lat_r5_hit");
    rd_dut(0, 7, "lat_r0_hit");
    frz = 1'b0; tick(1); frz = 1'b1;
    rd_dut(5, 1, "lat_r5_after");
    rd_dut(0, 8, "lat_r0_after");

    // priority: 5 and 22 together charge 22; instret counts separately
    clr = 1'b1; tick(1); clr = 1'b0;
    frz = 1'b0;
    ev = (33'd1 << 5) | (33'd1 << 22);
    tick(1);
    ev = '0;
    tick(7);
    inst = 1'b1;
    tick(3);
    inst = 1'b0;
    frz = 1'b1;
    rd_dut(22, 1, "prio_r22");
    rd_dut(5, 0, "prio_r5");
    rd_dut(0, 7, "prio_r0");
    rd_dut(33, 3, "prio_instret");

    // freeze holds pipe and counters despite events and instret
    frz = 1'b0;
    ev = 33'd1 << 9;
    tick(1);
    ev = '0;
    tick(3);
    frz = 1'b1;
    ev = (33'd1 << 30) | (33'd1 << 2);
    inst = 1'b1;
    tick(5);
    ev = '0;
    inst = 1'b0;
    rd_dut(0, 11, "frz_r0");
    rd_dut(33, 3, "frz_instret");
    rd_dut(30, 0, "frz_r30");
    rd_dut(9, 0, "frz_r9");
    frz = 1'b0;
    tick(3);
    frz = 1'b1;
    rd_dut(9, 0, "resume_r9_early");
    frz = 1'b0;
    tick(1);
    frz = 1'b1;
    rd_dut(9, 1, "resume_r9");
    rd_dut(0, 14, "resume_r0");
    rd_dut(30, 0, "resume_r30");
    rd_dut(2, 0, "resume_r2");

    // clear wins over a same-cycle instret increment
    frz = 1'b0; inst = 1'b1; clr = 1'b1;
    tick(1);
    clr = 1'b0; inst = 1'b0; frz = 1'b1;
    rd_dut(33, 0, "clr_instret");
    rd_dut(0, 0, "clr_r0");
    rd_dut(22, 0, "clr_r22");

    // 4-bit counters saturate at 15 and raise sticky sat_o
    clr_s = 1'b1; tick(1); clr_s = 1'b0;
    chk("sat_after_clr", 32'(sat_s), 32'd0);
    ev_s = 33'd1 << 12;
    tick(10);
    chk("sat_not_yet", 32'(sat_s), 32'd0);
    tick(10);
    ev_s = '0;
    frz_s = 1'b1;
    chk("sat_set", 32'(sat_s), 32'd1);
    rd_sat(12, 15, "sat_r12");
    rd_sat(0, 1, "sat_r0");
    chk("sat_sticky", 32'(sat_s), 32'd1);
    // read in the clear cycle returns the pre-clear value
    rdv_s = 1'b1; rda_s = 6'd12; clr_s = 1'b1;
    tick(1);
    rdv_s = 1'b0; clr_s = 1'b0;
    chk("clr_rd_v", 32'(rvo_s), 32'd1);
    chk("clr_rd_preval", {28'd0, rdd_s}, 32'd15);
    chk("sat_cleared", 32'(sat_s), 32'd0);
    rd_sat(12, 0, "sat_r12_clr");

`ifdef BP_CORE_STALL_HIST_SNAPSHOT_EN
    // snapshot after 3 counts, 4 more counts stay invisible
    clr = 1'b1; tick(1); clr = 1'b0;
    frz = 1'b0;
    inst = 1'b1;
    tick(2);
    snap = 1'b1;
    tick(1);
    snap = 1'b0;
    tick(4);
    inst = 1'b0;
    frz = 1'b1;
    rd_raw(33, 3, "snap_first");
    clr = 1'b1; tick(1); clr = 1'b0;
    rd_raw(33, 3, "snap_keeps_after_clr");
    snap = 1'b1; tick(1); snap = 1'b0;
    rd_raw(33, 0, "snap_second");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
